seven_segment_scan: RTL and testbench
=====================================

# seven_segment_scan

Time-multiplexed driver for a bank of DIGITS common-anode/cathode seven-segment displays, replacing per-digit static decoders. Latches a packed hex value plus decimal points, decodes one digit per scan slot, drives the shared segment bus and one-hot digit enables, and applies leading-zero blanking and inter-digit guard blanking. Sits between the datapath's display registers and the board pins.

## Interface
- DIGITS, 4: number of digits scanned (1–8).
- PRESCALE, 50000: clock cycles per digit slot (≥ 4).
- GUARD, 4: cycles at the start of each slot with all digits off (0 ≤ GUARD < PRESCALE).
- ACTIVE_LOW, 1: 1 → segment, dp_out and anode drive 0 to light; 0 → drive 1 to light.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- load  in  1  single-cycle strobe capturing value/dp.
- value  in  4*DIGITS  packed hex digits; value[4i+3:4i] is digit i, digit 0 rightmost.
- dp  in  DIGITS  decimal point per digit.
- enable  in  1  0 → all digits dark; scanning continues.
- lz_blank  in  1  1 → leading-zero blanking on.
- segment  out  7  segment[0]=a … segment[6]=g, registered.
- dp_out  out  1  decimal point of current digit, registered.
- anode  out  DIGITS  one-hot digit enable, registered.
- frame  out  1  one-cycle pulse at end of each full scan.

## Operation
- Prescaler cnt counts 0..PRESCALE-1; at PRESCALE-1, cnt→0 and digit index idx increments, wrapping DIGITS-1→0.
- Double buffer: load writes pending ← {value, dp}. At the wrap edge (idx=DIGITS-1, cnt=PRESCALE-1) active ← pending. If load coincides with the wrap edge, the value being loaded goes straight into both pending and active. Display never tears mid-frame.
- Decode (active-high internal): 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07, 8→7F, 9→6F, A→77, B→7C, C→39, D→5E, E→79, F→71. Output inverted when ACTIVE_LOW=1.
- Leading-zero blanking (lz_blank=1): digit i>0 blanks if it and every digit above it are 0 and none of them has dp set. Digit 0 is never blanked. Blanked digit: segments and dp off, anode still asserted.
- Guard: when cnt < GUARD, anode all inactive.
- enable=0: anode all inactive, segment off, dp_out off. Prescaler, idx, buffers and frame keep running.

## Timing
- All outputs registered from (idx, cnt, active, enable, lz_blank): they reflect the state of the previous cycle (1-cycle latency).
- Slot k: anode[k] active for cycles GUARD+1..PRESCALE of slot k (relative to the edge where idx becomes k), i.e. PRESCALE-GUARD cycles. segment/dp_out change on the same edge anode goes inactive.
- Frame period = DIGITS*PRESCALE cycles. frame asserts for one cycle, one cycle after the wrap edge.
- load→visible: first slot of the frame after the next wrap edge, worst case DIGITS*PRESCALE+GUARD+1 cycles.
- Reset (asynchronous, any time incl. mid-slot): cnt=0, idx=0, pending=active=0, anode all inactive, segment off (7F if ACTIVE_LOW else 00), dp_out off, frame=0. Scanning resumes from digit 0 on the first edge after release.

## Structure
- Shared package seven_seg_pkg: 16-entry hex-to-segment constant table (active-high), SEG_OFF constant, polarity-apply function.
- One sub-module seg_decode: combinational 4-bit → 7-bit lookup from the package table. Scan/buffer/blank logic stays in seven_segment_scan.

## Test plan
- Reset mid-slot with DIGITS=4, PRESCALE=8, GUARD=2, ACTIVE_LOW=1 → next cycle anode=1111, segment=1111111, dp_out=1, frame=0. Digit 0 lit at cycle 3 after release.
- DIGITS=1: load 0..F sequentially, each held one frame → segment sequence 1000000, 1111001, …, 0001000 (A), …, 0001110 (F).
- Load 0x1234 mid-frame → current frame still shows 0000. Next frame anode order 1110→1101→1011→0111 with digits 4,3,2,1. frame pulses every 32 cycles.
- lz_blank=1, value 0x0050, dp=0000 → digits 3,2 dark (segment 1111111), digit 1 shows 5, digit 0 shows 0. Setting dp=0100 → digit 2 shows 0 with dp lit.
- load asserted exactly on the wrap edge with 0xBEEF → following frame shows B,E,E,F with no extra frame delay.
- enable=0 for one frame → anode=1111 throughout, frame still pulses. Re-enable resumes in the correct slot.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scanner: hex-to-segment table (active-high,
// bit 0 = a ... bit 6 = g), the dark pattern and a polarity helper.
package seven_seg_pkg;

    localparam logic [6:0] SEG_OFF = 7'h00;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] apply_polarity(input logic [6:0] seg, input logic active_low);
        return active_low ? ~seg : seg;
    endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational hex digit to active-high segment pattern lookup.
module seg_decode
    import seven_seg_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = HEX_SEG[digit];
    end

endmodule

// File: rtl/seven_segment_scan.sv
// Time-multiplexed seven-segment driver: double-buffered value, one digit per slot,
// leading-zero blanking and guard-blanked digit enables, all outputs registered.
module seven_segment_scan
    import seven_seg_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int PRESCALE   = 50000,
    parameter int GUARD      = 4,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  enable,
    input  logic                  lz_blank,
    output logic [6:0]            segment,
    output logic                  dp_out,
    output logic [DIGITS-1:0]     anode,
    output logic                  frame
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W = $clog2(PRESCALE);
    localparam int BUF_W = 5 * DIGITS;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);
    localparam logic             POL_LOW   = (ACTIVE_LOW != 0);

    logic [CNT_W-1:0] cnt_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [BUF_W-1:0] pending_reg;
    logic [BUF_W-1:0] active_reg;

    logic [BUF_W-1:0] load_word;
    logic             slot_end;
    logic             wrap;

    assign load_word = {value, dp};
    assign slot_end  = (cnt_reg == CNT_LAST);
    assign wrap      = slot_end && (idx_reg == IDX_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg     <= '0;
            idx_reg     <= '0;
            pending_reg <= '0;
            active_reg  <= '0;
        end else begin
            cnt_reg <= slot_end ? '0 : cnt_reg + 1'b1;
            if (slot_end) begin
                idx_reg <= (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
            end
            if (load) begin
                pending_reg <= load_word;
            end
            // A load landing on the wrap edge bypasses pending so it shows next frame.
            if (wrap) begin
                active_reg <= load ? load_word : pending_reg;
            end
        end
    end

    logic [4*DIGITS-1:0] active_value;
    logic [DIGITS-1:0]   active_dp;
    logic [3:0]          digit_arr [DIGITS];
    logic [DIGITS-1:0]   is_zero;
    logic [DIGITS-1:0]   blank_vec;
    logic [DIGITS-1:0]   anode_on;
    logic                lit_slot;

    assign active_value = active_reg[BUF_W-1:DIGITS];
    assign active_dp    = active_reg[DIGITS-1:0];
    assign lit_slot     = (cnt_reg >= CNT_GUARD);

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign digit_arr[gi] = active_value[4*gi +: 4];
            assign is_zero[gi]   = (active_value[4*gi +: 4] == 4'h0) && !active_dp[gi];
            assign anode_on[gi]  = enable && lit_slot && (idx_reg == IDX_W'(gi));
            if (gi == 0) begin : g_first
                assign blank_vec[gi] = 1'b0;
            end else begin : g_upper
                // Blank only while this digit and everything to its left is a bare zero.
                assign blank_vec[gi] = lz_blank && (&is_zero[DIGITS-1:gi]);
            end
        end
    endgenerate

    logic [3:0] digit_cur;
    logic [6:0] seg_raw;
    logic       show;

    assign digit_cur = digit_arr[idx_reg];
    assign show      = enable && !blank_vec[idx_reg];

    seg_decode u_decode (
        .digit (digit_cur),
        .seg   (seg_raw)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            segment <= apply_polarity(SEG_OFF, POL_LOW);
            dp_out  <= POL_LOW;
            anode   <= POL_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
            frame   <= 1'b0;
        end else begin
            segment <= apply_polarity(show ? seg_raw : SEG_OFF, POL_LOW);
            dp_out  <= (show && active_dp[idx_reg]) ^ POL_LOW;
            anode   <= POL_LOW ? ~anode_on : anode_on;
            frame   <= wrap;
        end
    end

endmodule

// File: tb/tb_seven_segment_scan.sv
// Directed bench: 4-digit scanner (PRESCALE=8, GUARD=2, active-low) plus a 1-digit instance.
module tb_seven_segment_scan;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        enable;
    logic        lz_blank;
    logic [6:0]  segment;
    logic        dp_out;
    logic [3:0]  anode;
    logic        frame;

    logic        load_b;
    logic [3:0]  value_b;
    logic [0:0]  dp_b;
    logic [6:0]  segment_b;
    logic        dp_out_b;
    logic [0:0]  anode_b;
    logic        frame_b;

    int n_vec = 0;
    int n_bad = 0;

    seven_segment_scan #(.DIGITS(4), .PRESCALE(8), .GUARD(2), .ACTIVE_LOW(1)) dut (
        .clk(clk), .reset(reset), .load(load), .value(value), .dp(dp),
        .enable(enable), .lz_blank(lz_blank), .segment(segment), .dp_out(dp_out),
        .anode(anode), .frame(frame)
    );

    seven_segment_scan #(.DIGITS(1), .PRESCALE(4), .GUARD(1), .ACTIVE_LOW(1)) dut_b (
        .clk(clk), .reset(reset), .load(load_b), .value(value_b), .dp(dp_b),
        .enable(1'b1), .lz_blank(1'b0), .segment(segment_b), .dp_out(dp_out_b),
        .anode(anode_b), .frame(frame_b)
    );

    typedef struct {
        logic [15:0] value;
        logic [3:0]  dp;
        logic        lz;
        logic [27:0] seg;   // {digit3, digit2, digit1, digit0}, active-low
        logic [3:0]  dpo;   // expected dp_out per digit, active-low
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic wait_frame(input bit which);
        bit got = 1'b0;
        for (int i = 0; i < 80 && !got; i++) begin
            @(negedge clk);
            got = which ? frame_b : frame;
        end
        n_vec++;
        if (!got) begin
            n_bad++;
            $display("FAIL frame_timeout: got no pulse, expected one within 80 cycles");
        end
    endtask

    // Entered just after a wrap edge; samples each slot mid-way through its lit window.
    task automatic check_frame(input string tag, input logic [27:0] seg, input logic [3:0] dpo);
        logic [3:0] exp_an;
        for (int k = 0; k < 4; k++) begin
            repeat (k == 0 ? 5 : 8) @(negedge clk);
            exp_an = ~(4'b0001 << k);
            check({tag, "_anode"}, {28'h0, anode}, {28'h0, exp_an});
            check({tag, "_seg"}, {25'h0, segment}, {25'h0, seg[7*k +: 7]});
            check({tag, "_dp"}, {31'h0, dp_out}, {31'h0, dpo[k]});
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic lz);
        value = v; dp = d; lz_blank = lz; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    vec_t       vecs [7];
    logic [6:0] lut_b [16];
    int         c;

    initial begin
        vecs[0] = '{16'h0050, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b1111};
        vecs[1] = '{16'h0050, 4'b0100, 1'b1, {7'h7F, 7'h40, 7'h12, 7'h40}, 4'b1011};
        vecs[2] = '{16'hA9C8, 4'b1010, 1'b0, {7'h08, 7'h10, 7'h46, 7'h00}, 4'b0101};
        vecs[3] = '{16'h0000, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111};
        vecs[4] = '{16'h0007, 4'b1000, 1'b1, {7'h40, 7'h40, 7'h40, 7'h78}, 4'b0111};
        vecs[5] = '{16'h0000, 4'b0000, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111};
        vecs[6] = '{16'h6D3E, 4'b0001, 1'b1, {7'h02, 7'h21, 7'h30, 7'h06}, 4'b1110};
        lut_b = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

        reset = 1'b1; load = 1'b0; value = '0; dp = '0; enable = 1'b1; lz_blank = 1'b0;
        load_b = 1'b0; value_b = '0; dp_b = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (13) @(negedge clk);

        // Asynchronous reset in the middle of a slot
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("rst_anode", {28'h0, anode}, 32'hF);
        check("rst_seg", {25'h0, segment}, 32'h7F);
        check("rst_dp", {31'h0, dp_out}, 32'h1);
        check("rst_frame", {31'h0, frame}, 32'h0);
        check("rst_seg_b", {25'h0, segment_b}, 32'h7F);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("guard_c1", {28'h0, anode}, 32'hF);
        @(negedge clk);
        check("guard_c2", {28'h0, anode}, 32'hF);
        @(negedge clk);
        check("lit_c3", {28'h0, anode}, 32'hE);
        check("lit_c3_seg", {25'h0, segment}, 32'h40);

        // Mid-frame load must not tear the frame in progress
        repeat (2) @(negedge clk);
        do_load(16'h1234, 4'b0000, 1'b0);
        repeat (7) @(negedge clk);
        check("tear_s1", {24'h0, anode, 1'b0, segment}, {24'h0, 4'b1101, 1'b0, 7'h40});
        repeat (8) @(negedge clk);
        check("tear_s2", {24'h0, anode, 1'b0, segment}, {24'h0, 4'b1011, 1'b0, 7'h40});
        repeat (8) @(negedge clk);
        check("tear_s3", {24'h0, anode, 1'b0, segment}, {24'h0, 4'b0111, 1'b0, 7'h40});
        wait_frame(1'b0);
        check_frame("v1234", {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111);

        wait_frame(1'b0);
        @(negedge clk);
        check("frame_width", {31'h0, frame}, 32'h0);
        c = 1;
        while (!frame && c < 100) begin
            @(negedge clk);
            c++;
        end
        check("frame_period", c, 32);

        for (int i = 0; i < 7; i++) begin
            do_load(vecs[i].value, vecs[i].dp, vecs[i].lz);
            wait_frame(1'b0);
            check_frame($sformatf("vec%0d", i), vecs[i].seg, vecs[i].dpo);
        end

        // Load coinciding with the wrap edge shows in the very next frame
        wait_frame(1'b0);
        repeat (31) @(negedge clk);
        do_load(16'hBEEF, 4'b0000, 1'b0);
        check("wrap_frame", {31'h0, frame}, 32'h1);
        check_frame("beef", {7'h03, 7'h06, 7'h06, 7'h0E}, 4'b1111);

        // One dark frame, scanning and frame pulses continue
        wait_frame(1'b0);
        enable = 1'b0;
        for (int k = 0; k < 4; k++) begin
            repeat (k == 0 ? 5 : 8) @(negedge clk);
            check("dark", {20'h0, anode, 1'b0, segment, dp_out}, {20'h0, 4'hF, 1'b0, 7'h7F, 1'b1});
        end
        wait_frame(1'b0);
        enable = 1'b1;
        check_frame("reen", {7'h03, 7'h06, 7'h06, 7'h0E}, 4'b1111);

        // Single-digit instance: walk all sixteen hex codes
        for (int v = 0; v < 16; v++) begin
            value_b = 4'(v);
            load_b = 1'b1;
            @(negedge clk);
            load_b = 1'b0;
            wait_frame(1'b1);
            repeat (3) @(negedge clk);
            check($sformatf("one_digit_%0h", v), {24'h0, anode_b, segment_b}, {24'h0, 1'b0, lut_b[v]});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
